// File: rtl/serial_alu_if.sv
// Request/response bundle for the bit-serial ALU: operand request in, flagged result out.
interface serial_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  carry;
  logic                  overflow;
  logic                  zero;
  logic                  err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero, err
  );
endinterface

// File: rtl/serial_alu.sv
// Bit-serial ALU: one operand bit per clock, LSB first, with ADD/SUB/NOT/AND/OR/XOR,
// carry/overflow/zero/err flags and valid/ready request and response handshakes.
module serial_alu #(
  parameter int DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  serial_alu_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] a_sh_reg;
  logic [DATA_WIDTH-1:0] b_sh_reg;
  logic [DATA_WIDTH-1:0] res_sh_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic [2:0]            op_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  c_reg;
  logic                  carry_reg;
  logic                  overflow_reg;
  logic                  zero_reg;
  logic                  err_reg;
  logic                  out_valid_reg;

  logic                  b_bit;
  logic                  sum_bit;
  logic                  cout;
  logic                  r_bit;
  logic                  is_arith;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] res_sh_next;

  always_comb begin
    is_arith    = (op_reg == OP_ADD) || (op_reg == OP_SUB);
    // Subtraction is a + ~b + 1; the +1 comes from the carry register's initial value.
    b_bit       = (op_reg == OP_SUB) ? ~b_sh_reg[0] : b_sh_reg[0];
    sum_bit     = a_sh_reg[0] ^ b_bit ^ c_reg;
    cout        = (a_sh_reg[0] & b_bit) | (a_sh_reg[0] & c_reg) | (b_bit & c_reg);
    r_bit       = sum_bit;
    case (op_reg)
      OP_NOT:  r_bit = ~a_sh_reg[0];
      OP_AND:  r_bit = a_sh_reg[0] & b_sh_reg[0];
      OP_OR:   r_bit = a_sh_reg[0] | b_sh_reg[0];
      OP_XOR:  r_bit = a_sh_reg[0] ^ b_sh_reg[0];
      default: r_bit = sum_bit;
    endcase
    res_sh_next = {r_bit, res_sh_reg[DATA_WIDTH-1:1]};
    last_bit    = (cnt_reg == CW'(DATA_WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      res_sh_reg    <= '0;
      result_reg    <= '0;
      op_reg        <= '0;
      cnt_reg       <= '0;
      c_reg         <= 1'b0;
      carry_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      zero_reg      <= 1'b0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.op <= OP_XOR) begin
              a_sh_reg  <= bus.a;
              b_sh_reg  <= bus.b;
              op_reg    <= bus.op;
              cnt_reg   <= '0;
              c_reg     <= (bus.op == OP_SUB);
              state_reg <= BUSY;
            end else begin
              // Illegal opcode: respond immediately; zero stays 0 even though result is 0.
              result_reg    <= '0;
              carry_reg     <= 1'b0;
              overflow_reg  <= 1'b0;
              zero_reg      <= 1'b0;
              err_reg       <= 1'b1;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        BUSY: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_sh_reg <= res_sh_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (is_arith) begin
            c_reg <= cout;
          end
          if (last_bit) begin
            // c_reg still holds the carry into the MSB here.
            result_reg    <= res_sh_next;
            zero_reg      <= (res_sh_next == '0);
            carry_reg     <= is_arith ? cout : 1'b0;
            overflow_reg  <= is_arith ? (c_reg ^ cout) : 1'b0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.carry     = carry_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.zero      = zero_reg;
  assign bus.err       = err_reg;
endmodule
